// File: rtl/mdu_div.sv
// -----------------------------------------------------------------------------
// mdu_div -- iterative 32-bit integer divider for the MIPS multiply/divide unit.
//
// Runs DIV (two's complement) and DIVU (unsigned). It uses one restoring
// shift-subtract step per cycle, 32 steps in all. The magnitudes are divided
// and the signs are applied in the DONE cycle. A zero divisor skips the
// iterations and returns quotient all-ones and remainder = dividend.
//
// Ports
//   clk_i       single clock, rising edge
//   rst_i       asynchronous reset, active low
//   start_i     begin an operation (sampled only in IDLE)
//   signed_i    1 = DIV, 0 = DIVU (sampled with start_i)
//   cancel_i    pipeline flush; aborts the operation in progress
//   a_i, b_i    dividend / divisor (sampled with start_i)
//   busy_o      divider occupied; EX stalls while high
//   done_o      one-cycle result pulse
//   hi_o, lo_o  remainder / quotient; hold the last result outside DONE
//   hilo_we_o   HILO write enable {hi,lo}; 2'b11 only together with done_o
// -----------------------------------------------------------------------------
module mdu_div #(
  parameter int ITER_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        cancel_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [1:0]  hilo_we_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [4:0] LAST_ITER = 5'(ITER_CYCLES - 1);

  state_e      state_q, state_d;

  // Operation context latched when a start is accepted.
  logic        signed_q,   signed_d;
  logic        sign_a_q,   sign_a_d;
  logic        sign_b_q,   sign_b_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] divisor_q,  divisor_d;

  // Iteration state. quot_q starts as the dividend magnitude. Dividend bits
  // shift out of the top while quotient bits shift in at the bottom.
  logic [32:0] rem_q,  rem_d;
  logic [31:0] quot_q, quot_d;
  logic [4:0]  cnt_q,  cnt_d;

  // Last delivered result, shown on hi_o/lo_o outside DONE.
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic [31:0] a_mag, b_mag;
  logic [33:0] trial;
  logic        q_bit;
  logic [32:0] rem_step;
  logic [31:0] quot_step;
  logic        neg_quot, neg_rem;
  logic [31:0] hi_pre, hi_fix, lo_fix;

  // ---------------------------------------------------------------------------
  // Accept and operand conditioning
  // ---------------------------------------------------------------------------
  // cancel_i outranks start_i, so a start that arrives alongside a flush is dropped.
  assign accept = (state_q == S_IDLE) && start_i && !cancel_i;

  assign a_mag = (signed_i && a_i[31]) ? (32'd0 - a_i) : a_i;
  assign b_mag = (signed_i && b_i[31]) ? (32'd0 - b_i) : b_i;

  // ---------------------------------------------------------------------------
  // One restoring step. The shifted remainder is always below twice the
  // divisor, so a 34-bit difference gives its sign in bit 33.
  // ---------------------------------------------------------------------------
  assign trial     = {rem_q, quot_q[31]} - {2'b00, divisor_q};
  assign q_bit     = ~trial[33];
  assign rem_step  = q_bit ? trial[32:0] : {rem_q[31:0], quot_q[31]};
  assign quot_step = {quot_q[30:0], q_bit};

  // ---------------------------------------------------------------------------
  // Sign fix-up. The quotient is negated on differing signs and the remainder
  // follows the dividend's sign. For a zero divisor, quot_q still holds the
  // dividend magnitude, so re-applying the dividend sign recovers a_i exactly.
  // 0x8000_0000 / -1 falls out naturally: the magnitude quotient is
  // 0x8000_0000, and it is not negated because the signs match.
  // ---------------------------------------------------------------------------
  assign neg_quot = signed_q & (sign_a_q ^ sign_b_q);
  assign neg_rem  = signed_q & sign_a_q;
  assign hi_pre   = div_zero_q ? quot_q : rem_q[31:0];
  assign hi_fix   = neg_rem ? (32'd0 - hi_pre) : hi_pre;
  assign lo_fix   = div_zero_q ? 32'hFFFF_FFFF
                  : (neg_quot ? (32'd0 - quot_q) : quot_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process evaluation order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default on entry means no path through the block leaves a
    // variable unassigned, so no latch can be inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (b_i == 32'd0) ? S_DONE : S_DIV;
        end
      end
      S_DIV: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // DONE always lasts one cycle. A start_i seen here is ignored.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    hilo_we_o = 2'b00;
    hi_o      = hi_q;
    lo_o      = lo_q;
    unique case (state_q)
      S_IDLE: begin
        // Raised in the accepting cycle so EX stalls without a bubble. It is
        // gated by reset because start_i may be high while the block is held
        // in reset.
        busy_o = accept & rst_i;
      end
      S_DIV: begin
        busy_o = 1'b1;
      end
      S_DONE: begin
        done_o    = ~cancel_i;
        hilo_we_o = cancel_i ? 2'b00 : 2'b11;
        hi_o      = hi_fix;
        lo_o      = lo_fix;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    signed_d   = signed_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    if (accept) begin
      signed_d   = signed_i;
      sign_a_d   = a_i[31];
      sign_b_d   = b_i[31];
      div_zero_d = (b_i == 32'd0);
      divisor_d  = b_mag;
      quot_d     = a_mag;
      rem_d      = '0;
      cnt_d      = '0;
    end else if (state_q == S_DIV && !cancel_i) begin
      rem_d  = rem_step;
      quot_d = quot_step;
      cnt_d  = cnt_q + 5'd1;
    end

    // A flushed result is never delivered, so it is not kept as the held value.
    if (state_q == S_DONE && !cancel_i) begin
      hi_d = hi_fix;
      lo_d = lo_fix;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: the datapath is reset too, not only the FSM. A reset must clear
      // the held hi_o/lo_o results, and the first start after reset must
      // behave exactly as it does from power-up.
      signed_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      signed_q   <= signed_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_div.sv
// -----------------------------------------------------------------------------
// tb_mdu_div -- self-checking bench for mdu_div.
// Directed vectors come from a table, followed by hand-written sequences for
// cancel, asynchronous reset and held start, then random operands compared
// against an arithmetic model of MIPS DIV/DIVU.
// -----------------------------------------------------------------------------
module tb_mdu_div;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        signed_i;
  logic        cancel_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [1:0]  hilo_we_o;

  mdu_div #(.ITER_CYCLES(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .signed_i (signed_i),
    .cancel_i (cancel_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .hilo_we_o(hilo_we_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // Count result pulses late in each cycle, well after any input change.
  always begin
    @(posedge clk_i);
    #8;
    if (done_o) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU. The quotient truncates toward zero, the
  // remainder takes the dividend's sign, results wrap modulo 2^32, and a zero
  // divisor yields {hi,lo} = {a, all-ones}. Returns {hi, lo}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Issue one operation and check everything observable about it. Start is
  // driven for one cycle, then the operand inputs are scrambled to prove the
  // operands were latched.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_cyc);
    int cyc;
    @(negedge clk_i);
    start_i  = 1'b1;
    signed_i = s;
    a_i      = a;
    b_i      = b;
    #1 check({tag, " busy_at_start"}, 64'(busy_o), 64'd1);
    @(negedge clk_i);
    start_i  = 1'b0;
    signed_i = 1'($urandom);
    a_i      = $urandom;
    b_i      = $urandom;
    cyc = 1;
    while (!done_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " result"}, {hi_o, lo_o}, {exp_hi, exp_lo});
    check({tag, " we"}, 64'(hilo_we_o), 64'd3);
    @(negedge clk_i);
    check({tag, " pulse_end"}, {62'd0, done_o, busy_o}, 64'd0);
    check({tag, " hold"}, {hi_o, lo_o}, {exp_hi, exp_lo});
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int cyc;
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] exp;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd2,         32'd14,        33};
    vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[2]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'd1,         32'hFFFF_FFFD, 33};
    vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,         32'h8000_0000, 33};
    vecs[4]  = '{32'd5,         32'd0,         1'b0, 32'd5,         32'hFFFF_FFFF, 1};
    vecs[5]  = '{32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};
    vecs[6]  = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         32'hFFFF_FFFF, 33};
    vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'd1,         33};
    vecs[8]  = '{32'd0,         32'd5,         1'b1, 32'd0,         32'd0,         33};
    vecs[9]  = '{32'd3,         32'd10,        1'b0, 32'd3,         32'd0,         33};
    vecs[10] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFE, 32'd14,        33};
    vecs[11] = '{32'hFFFF_FFF9, 32'd2,         1'b0, 32'd1,         32'h7FFF_FFFC, 33};
    vecs[12] = '{32'h8000_0000, 32'd2,         1'b1, 32'd0,         32'hC000_0000, 33};

    // Reset state, with start_i high to show it cannot leak through.
    rst_i = 1'b0; start_i = 1'b1; signed_i = 1'b0; cancel_i = 1'b0;
    a_i = 32'd10; b_i = 32'd3;
    repeat (3) @(negedge clk_i);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done_we", {61'd0, done_o, hilo_we_o}, 64'd0);
    check("reset hilo", {hi_o, lo_o}, 64'd0);
    start_i = 1'b0;
    rst_i   = 1'b1;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
              vecs[i].hi, vecs[i].lo, vecs[i].cyc);
    end

    // Cancel at iteration 10, then an immediate new start.
    d0 = done_cnt;
    @(negedge clk_i);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    cancel_i = 1'b1;
    #1 check("cancel_div gated", {61'd0, done_o, hilo_we_o}, 64'd0);
    @(negedge clk_i);
    cancel_i = 1'b0;
    #1 check("cancel_div idle", 64'(busy_o), 64'd0);
    run_div("after_cancel 9/3", 32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 33);
    check("cancel_div pulses", 64'(done_cnt - d0), 64'd1);

    // Cancel during DONE gates the pulse combinationally.
    d0 = done_cnt;
    @(negedge clk_i);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd77; b_i = 32'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    check("cancel_done reached", 64'(done_o), 64'd1);
    cancel_i = 1'b1;
    #1 check("cancel_done gated", {61'd0, done_o, hilo_we_o}, 64'd0);
    @(negedge clk_i);
    cancel_i = 1'b0;
    #1 check("cancel_done idle", {62'd0, busy_o, done_o}, 64'd0);
    check("cancel_done pulses", 64'(done_cnt - d0), 64'd0);

    // cancel_i outranks start_i in IDLE.
    d0 = done_cnt;
    @(negedge clk_i);
    start_i = 1'b1; cancel_i = 1'b1; a_i = 32'd50; b_i = 32'd5;
    #1 check("cancel_vs_start busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    start_i = 1'b0; cancel_i = 1'b0;
    #1 check("cancel_vs_start not_taken", 64'(busy_o), 64'd0);
    repeat (40) @(negedge clk_i);
    check("cancel_vs_start pulses", 64'(done_cnt - d0), 64'd0);

    // Asynchronous reset between edges in the middle of DIV.
    @(negedge clk_i);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd12345; b_i = 32'd7;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    @(posedge clk_i);
    #2 start_i = 1'b1;
    rst_i = 1'b0;
    #1 check("async_rst busy", 64'(busy_o), 64'd0);
    check("async_rst done_we", {61'd0, done_o, hilo_we_o}, 64'd0);
    check("async_rst hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    rst_i   = 1'b1;
    d0 = done_cnt;
    run_div("after_rst 100/7", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 33);
    check("after_rst pulses", 64'(done_cnt - d0), 64'd1);

    // start_i held high from acceptance through DONE: exactly one result.
    d0 = done_cnt;
    @(negedge clk_i);
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd20; b_i = 32'd6;
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!done_o && cyc < 100);
    check("held_start latency", 64'(cyc), 64'd33);
    check("held_start busy_in_done", 64'(busy_o), 64'd0);
    check("held_start result", {hi_o, lo_o}, {32'd2, 32'd3});
    start_i = 1'b0;
    repeat (40) @(negedge clk_i);
    check("held_start pulses", 64'(done_cnt - d0), 64'd1);

    // Random operands, biased toward the interesting corners.
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 16);
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 100);
        default: ra = $urandom;
      endcase
      rs  = 1'($urandom);
      exp = ref_div(ra, rb, rs);
      run_div($sformatf("rand%0d %h/%h s%0d", n, ra, rb, rs), ra, rb, rs,
              exp[63:32], exp[31:0], (rb == 32'd0) ? 1 : 33);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
